// File: rtl/adc_capture_pkg.sv
// rtl/adc_capture_pkg.sv - shared constants for the adc_capture block
//
// Purpose: FSM state encodings and the pulse-width saturation limit, shared
//          by the capture top level and anything that decodes its state.
// Ports:   none (package).

package adc_capture_pkg;

  // Plain 3-bit constants rather than an enum so that older tools and the
  // readout firmware headers can share the same numeric encodings.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [7:0] WIDTH_MAX = 8'd255;

  // Saturating increment for the pulse-width counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == WIDTH_MAX) ? WIDTH_MAX : v + 8'd1;
  endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// rtl/adc_capture_ram.sv - DEPTH x 8 simple dual-port record buffer
//
// Purpose: sample ring buffer for adc_capture. One write port, one
//          synchronous read port with a registered output.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset (read register only)
//   i_we, i_waddr, i_wdata write port
//   i_re, i_raddr         read request; data appears on o_rdata next cycle
//   o_rdata               registered read data, 0 after reset

module capture_ram
  import adc_capture_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // Array kept free of reset so it can map onto distributed or block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Output register is reset so the readout bus idles at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= 8'd0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - pre/post-trigger waveform capture on an 8-bit sample stream
//
// Purpose: when armed, records samples into a ring buffer, triggers on an
//          upward threshold crossing, freezes a DEPTH-sample record holding
//          pre_samples pre-trigger samples, measures the pulse width, and
//          lets firmware pop the record back oldest first.
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_en                     sample-accept gate
//   i_arm                    start capture (honoured in IDLE/DONE)
//   i_din, i_din_valid       sample stream
//   i_threshold              trigger level, latched at arm
//   i_pre_samples            pre-trigger count, latched at arm
//   i_rd_en                  pop one record sample (DONE only)
//   o_rd_data, o_rd_valid    popped sample, one cycle after i_rd_en
//   o_busy                   capture in progress (FILL/WAIT/POST)
//   o_done                   record ready for readout
//   o_width                  pulse width in accepted samples, saturating

module adc_capture
  import adc_capture_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_arm,
  input  logic [7:0]    i_din,
  input  logic          i_din_valid,
  input  logic [7:0]    i_threshold,
  input  logic [AW-1:0] i_pre_samples,
  input  logic          i_rd_en,
  output logic [7:0]    o_rd_data,
  output logic          o_rd_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic [7:0]    o_width
);

  logic [2:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_cnt;
  logic [7:0]    r_prev;
  logic [7:0]    r_thr;
  logic [AW-1:0] r_pre;
  logic [AW-1:0] r_start_ptr;
  logic [AW-1:0] r_post_left;
  logic [7:0]    r_width;
  logic          r_width_run;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_rd_cnt;
  logic          r_rd_valid;

  logic          w_acc;
  logic          w_idle_or_done;
  logic          w_arm_go;
  logic          w_capturing;
  logic          w_we;
  logic          w_above;
  logic          w_trig;
  logic          w_pop;
  logic [AW-1:0] w_cnt_next;
  logic [AW-1:0] w_post_init;
  logic [AW-1:0] w_trig_start;
  logic [7:0]    w_ram_rdata;

  assign w_acc          = i_en && i_din_valid;
  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_arm_go       = i_arm && w_idle_or_done;
  assign w_capturing    = (r_state == ST_FILL) || (r_state == ST_WAIT) ||
                          (r_state == ST_POST);
  assign w_we           = w_acc && w_capturing;
  assign w_above        = (i_din >= r_thr);

  // prev starts at FF, so a signal already above threshold at arm time
  // has to dip below it before it can trigger.
  assign w_trig         = (r_state == ST_WAIT) && w_acc && w_above &&
                          (r_prev < r_thr);

  // arm takes priority over a pop in the same DONE cycle.
  assign w_pop          = (r_state == ST_DONE) && i_rd_en && !i_arm;

  assign w_cnt_next     = r_cnt + AW'(1);
  assign w_post_init    = AW'(DEPTH - 1) - r_pre;
  // Trigger sample lands at r_wr_ptr; the pre-trigger samples sit just
  // behind it in the ring.
  assign w_trig_start   = r_wr_ptr - r_pre;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_cnt       <= '0;
      r_prev      <= 8'd0;
      r_thr       <= 8'd0;
      r_pre       <= '0;
      r_start_ptr <= '0;
      r_post_left <= '0;
      r_width     <= 8'd0;
      r_width_run <= 1'b0;
      r_rd_ptr    <= '0;
      r_rd_cnt    <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_arm_go) begin
        r_thr       <= i_threshold;
        r_pre       <= i_pre_samples;
        r_wr_ptr    <= '0;
        r_cnt       <= '0;
        r_prev      <= 8'hFF;
        r_width     <= 8'd0;
        r_width_run <= 1'b1;
        r_state     <= (i_pre_samples != '0) ? ST_FILL : ST_WAIT;
      end else begin
        case (r_state)
          ST_FILL: begin
            if (w_acc) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
              r_prev   <= i_din;
              r_cnt    <= w_cnt_next;
              if (w_cnt_next == r_pre) begin
                r_state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (w_acc) begin
              r_wr_ptr <= r_wr_ptr + AW'(1);
              r_prev   <= i_din;
              if (w_trig) begin
                r_start_ptr <= w_trig_start;
                r_post_left <= w_post_init;
                r_width     <= 8'd1;
                if (w_post_init == '0) begin
                  r_state  <= ST_DONE;
                  r_rd_ptr <= w_trig_start;
                  r_rd_cnt <= '0;
                end else begin
                  r_state <= ST_POST;
                end
              end
            end
          end
          ST_POST: begin
            if (w_acc) begin
              r_wr_ptr    <= r_wr_ptr + AW'(1);
              r_post_left <= r_post_left - AW'(1);
              // Width only counts the first contiguous run above threshold.
              if (r_width_run) begin
                if (w_above) begin
                  r_width <= sat_inc8(r_width);
                end else begin
                  r_width_run <= 1'b0;
                end
              end
              if (r_post_left == AW'(1)) begin
                r_state  <= ST_DONE;
                r_rd_ptr <= r_start_ptr;
                r_rd_cnt <= '0;
              end
            end
          end
          ST_DONE: begin
            if (w_pop) begin
              r_rd_ptr <= r_rd_ptr + AW'(1);
              r_rd_cnt <= r_rd_cnt + AW'(1);
              if (r_rd_cnt == AW'(DEPTH - 1)) begin
                r_state <= ST_IDLE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  capture_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_din),
    .i_re    (w_pop),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  assign o_rd_data  = w_ram_rdata;
  assign o_rd_valid = r_rd_valid;
  assign o_busy     = w_capturing;
  assign o_done     = (r_state == ST_DONE);
  assign o_width    = r_width;

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - scoreboard testbench for adc_capture

module tb_adc_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  // DEPTH=32 instance
  logic       en, arm, dv, rd_en;
  logic [7:0] din, thr;
  logic [4:0] pre;
  logic [7:0] rd_data, width;
  logic       rd_valid, busy, done;

  // DEPTH=256 instance
  logic       b_en, b_arm, b_dv, b_rd_en;
  logic [7:0] b_din, b_thr;
  logic [7:0] b_pre;
  logic [7:0] b_rd_data, b_width;
  logic       b_rd_valid, b_busy, b_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] q32[$];
  logic [7:0] q256[$];
  logic [7:0] e32, e256;

  adc_capture #(.DEPTH(32)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_arm(arm), .i_din(din),
    .i_din_valid(dv), .i_threshold(thr), .i_pre_samples(pre), .i_rd_en(rd_en),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_busy(busy), .o_done(done),
    .o_width(width)
  );

  adc_capture #(.DEPTH(256)) u256 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .i_arm(b_arm), .i_din(b_din),
    .i_din_valid(b_dv), .i_threshold(b_thr), .i_pre_samples(b_pre), .i_rd_en(b_rd_en),
    .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .o_busy(b_busy), .o_done(b_done),
    .o_width(b_width)
  );

  // Monitors: every rd_valid pops one expected sample from the scoreboard.
  always @(negedge clk) begin
    if (rd_valid) begin
      total++;
      if (q32.size() == 0) begin
        bad++;
        $display("FAIL rd32_unexpected: rd_data=%0d but no sample expected", rd_data);
      end else begin
        e32 = q32.pop_front();
        if (rd_data !== e32) begin
          bad++;
          $display("FAIL rd32_data: got %0d expected %0d", rd_data, e32);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rd_valid) begin
      total++;
      if (q256.size() == 0) begin
        bad++;
        $display("FAIL rd256_unexpected: rd_data=%0d but no sample expected", b_rd_data);
      end else begin
        e256 = q256.pop_front();
        if (b_rd_data !== e256) begin
          bad++;
          $display("FAIL rd256_data: got %0d expected %0d", b_rd_data, e256);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] v);
    din = v; dv = 1'b1; en = 1'b1;
    tick();
  endtask

  task automatic arm_cap(input logic [7:0] t, input logic [4:0] p);
    thr = t; pre = p; dv = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pop32(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    tick();
    tick();
    chk(name, q32.size(), 0);
  endtask

  function automatic logic [7:0] pulse_val(input int idx);
    if (idx < 2 || idx >= 302) return 8'd0;
    return 8'(200 + ((idx - 2) % 50));
  endfunction

  int n;
  int idx;

  initial begin
    rst_n = 1'b0;
    en = 0; arm = 0; dv = 0; rd_en = 0; din = 0; thr = 0; pre = 0;
    b_en = 0; b_arm = 0; b_dv = 0; b_rd_en = 0; b_din = 0; b_thr = 0; b_pre = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_width", width, 0);
    chk("rst_width256", b_width, 0);
    rst_n = 1'b1;
    tick();

    // Basic ramp capture, pre=4, thr=100
    arm_cap(8'd100, 5'd4);
    n = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      feed(8'(i * 10));
      n++;
    end
    dv = 1'b0;
    chk("t1_samples_to_done", n, 38);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_width", width, 16);
    for (int k = 0; k < 32; k++) q32.push_back(8'(60 + 10 * k));
    for (int k = 0; k < 31; k++) begin
      rd_en = 1'b1;
      tick();
    end
    chk("t1_done_before_last_pop", done, 1);
    tick();
    rd_en = 1'b0;
    chk("t1_idle_after_last_pop", done, 0);
    tick(); tick();
    chk("t1_drain", q32.size(), 0);

    // Zero pre-trigger step
    arm_cap(8'd50, 5'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin feed(8'd0); n++; end
    for (int i = 0; i < 5; i++) begin feed(8'd200); n++; end
    for (int i = 0; i < 60 && !done; i++) begin feed(8'd0); n++; end
    dv = 1'b0;
    chk("t2_samples_to_done", n, 35);
    chk("t2_width", width, 5);
    for (int k = 0; k < 5; k++) q32.push_back(8'd200);
    for (int k = 0; k < 27; k++) q32.push_back(8'd0);
    pop32(32, "t2_drain");

    // Full pre-trigger: one post slot, then arm+rd_en in DONE
    arm_cap(8'd100, 5'd31);
    for (int k = 1; k <= 31; k++) feed(8'(k));
    chk("t3_busy_before_trig", busy, 1);
    chk("t3_done_before_trig", done, 0);
    feed(8'd150);
    dv = 1'b0;
    chk("t3_done_after_trig", done, 1);
    chk("t3_busy_after_trig", busy, 0);
    chk("t3_width", width, 1);
    for (int k = 1; k <= 31; k++) q32.push_back(8'(k));
    for (int k = 0; k < 31; k++) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b1; arm = 1'b1; thr = 8'd100; pre = 5'd31;
    tick();
    rd_en = 1'b0; arm = 1'b0;
    chk("t3_arm_pop_rd_valid", rd_valid, 0);
    chk("t3_rearm_busy", busy, 1);
    chk("t3_rearm_done", done, 0);
    tick();
    chk("t3_drain", q32.size(), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // No false trigger at arm, arm in WAIT ignored
    arm_cap(8'd100, 5'd0);
    for (int i = 0; i < 5; i++) feed(8'd200);
    chk("t4_no_false_trig_done", done, 0);
    thr = 8'd10; pre = 5'd5; arm = 1'b1;
    feed(8'd0);
    arm = 1'b0;
    feed(8'd0);
    feed(8'd150);
    for (int j = 1; j <= 31; j++) begin
      feed((j < 3) ? 8'd150 : 8'(j));
      if (j == 30) chk("t4_done_before_last", done, 0);
    end
    dv = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_width", width, 3);
    for (int k = 0; k < 3; k++) q32.push_back(8'd150);
    for (int k = 3; k <= 31; k++) q32.push_back(8'(k));
    pop32(32, "t4_drain");

    // Reset during POST
    arm_cap(8'd100, 5'd0);
    feed(8'd0);
    feed(8'd200);
    for (int i = 0; i < 3; i++) feed(8'd200);
    dv = 1'b0;
    chk("t5_busy_in_post", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_width", width, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      chk("t5_rd_valid_after_rst", rd_valid, 0);
    end
    rd_en = 1'b0;
    tick();

    // Gated input and width saturation on DEPTH=256
    b_thr = 8'd100; b_pre = 8'd0; b_arm = 1'b1;
    tick();
    b_arm = 1'b0;
    idx = 0;
    for (int c = 0; c < 2000 && !b_done; c++) begin
      b_en  = c[0];
      b_dv  = 1'b1;
      b_din = b_en ? pulse_val(idx) : 8'd7;
      tick();
      if (b_en) idx++;
    end
    b_dv = 1'b0; b_en = 1'b0;
    chk("t6_accepted_to_done", idx, 258);
    chk("t6_done", b_done, 1);
    chk("t6_width_sat", b_width, 255);
    for (int j = 0; j < 256; j++) q256.push_back(8'(200 + (j % 50)));
    for (int k = 0; k < 256; k++) begin
      b_rd_en = 1'b1;
      tick();
    end
    b_rd_en = 1'b0;
    tick(); tick();
    chk("t6_drain", q256.size(), 0);
    chk("t6_idle", b_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
